// File: rtl/vend_cmd_arbiter.sv
// Command arbiter: turns gesture pulses and key presses into one-hot, fixed-priority,
// gap-spaced command pulses for the vending datapath, holding them off while it is busy.
module vend_cmd_arbiter #(
  parameter int unsigned GAP_CYC = 32'd2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] gest_flag,
  input  logic [2:0] key,
  input  logic       busy,
  output logic [3:0] cmd_flag,
  output logic       cmd_src,
  output logic [3:0] pend,
  output logic [7:0] drop_cnt,
  output logic       idle
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  localparam logic [23:0] GAP_LD = GAP_CYC[23:0];

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  key_d_q, key_d_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  src_q, src_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [3:0]  cmd_flag_q, cmd_flag_d;
  logic        cmd_src_q, cmd_src_d;
  logic        idle_q, idle_d;

  logic [2:0]  key_rise_s;
  logic [3:0]  key_ev_s;
  logic [3:0]  grant_s;
  logic [2:0]  drops_s;
  logic [8:0]  drop_sum_s;

  // Event detection, pending-set bookkeeping, drop counting and FSM next state
  always_comb begin
    key_d_d    = key;
    key_rise_s = key & ~key_d_q;
    // Keys map onto commands: key2 -> cmd1, key1 -> cmd0, key0 -> cmd2.
    key_ev_s   = {1'b0, key_rise_s[0], key_rise_s[2], key_rise_s[1]};

    if ((state_q == ST_IDLE) && !busy && (pend_q != 4'b0000)) begin
      if (pend_q[2]) begin
        grant_s = 4'b0100;
      end else if (pend_q[1]) begin
        grant_s = 4'b0010;
      end else if (pend_q[0]) begin
        grant_s = 4'b0001;
      end else begin
        grant_s = 4'b1000;
      end
    end else begin
      grant_s = 4'b0000;
    end

    pend_d  = pend_q;
    src_d   = src_q;
    drops_s = 3'd0;
    if (busy) begin
      pend_d = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        drops_s = drops_s + {2'b00, gest_flag[i]} + {2'b00, key_ev_s[i]};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (gest_flag[i]) begin
          if (!pend_q[i] || grant_s[i]) begin
            pend_d[i] = 1'b1;
            src_d[i]  = 1'b1;
          end else begin
            drops_s = drops_s + 3'd1;
          end
          // A same-cycle key event for this command always loses to the gesture.
          drops_s = drops_s + {2'b00, key_ev_s[i]};
        end else if (key_ev_s[i]) begin
          if (!pend_q[i] || grant_s[i]) begin
            pend_d[i] = 1'b1;
            src_d[i]  = 1'b0;
          end else begin
            drops_s = drops_s + 3'd1;
          end
        end else begin
          pend_d[i] = pend_q[i] & ~grant_s[i];
        end
      end
    end

    drop_sum_s = {1'b0, drop_cnt_q} + {6'd0, drops_s};
    drop_cnt_d = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];

    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_flag_d = 4'b0000;
    cmd_src_d  = cmd_src_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s != 4'b0000) begin
          state_d    = ST_GAP;
          cnt_d      = GAP_LD;
          cmd_flag_d = grant_s;
          cmd_src_d  = |(grant_s & src_q);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q <= 24'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 24'd0;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 24'd0;
      end
    endcase

    idle_d = (state_d == ST_IDLE) && (pend_d == 4'b0000);
  end

  // State, pending register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 24'd0;
      key_d_q    <= 3'b000;
      pend_q     <= 4'b0000;
      src_q      <= 4'b0000;
      drop_cnt_q <= 8'd0;
      cmd_flag_q <= 4'b0000;
      cmd_src_q  <= 1'b0;
      idle_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_d_q    <= key_d_d;
      pend_q     <= pend_d;
      src_q      <= src_d;
      drop_cnt_q <= drop_cnt_d;
      cmd_flag_q <= cmd_flag_d;
      cmd_src_q  <= cmd_src_d;
      idle_q     <= idle_d;
    end
  end

  assign cmd_flag = cmd_flag_q;
  assign cmd_src  = cmd_src_q;
  assign pend     = pend_q;
  assign drop_cnt = drop_cnt_q;
  assign idle     = idle_q;

endmodule
